accum_job_loader: RTL and testbench
===================================

Name: accum_job_loader

Overview:
- Initiator and writer side of the accumulator's dut_valid/dut_ready plus SRAM protocol.
- Accepts a stream of 32-bit FP words and writes them to SRAM at addresses 1..N, then writes count N to address 0.
- Starts the accumulator with a dut_valid pulse and waits for completion via dut_ready.
- Reads the result word from address N+1 and presents it on a valid/ready output; owns the SRAM (sram_grant=1) except while the accumulator runs.

Parameters:
ADDR_W, 16, SRAM address width; max job length MAX_N = 2^ADDR_W - 2
TIMEOUT_CYC, 1024, max cycles allowed in WAIT_BUSY or WAIT_DONE before abort

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  loader accepts input word
in_data  input  32  FP32 data word
in_last  input  1  marks final word of job (qualified by in_valid)
dut_valid  output  1  start pulse to accumulator
dut_ready  input  1  accumulator idle (1) / busy (0)
sram_grant  output  1  1 = loader drives SRAM, 0 = accumulator drives SRAM
sram_write_enable  output  1  SRAM write strobe
sram_write_address  output  ADDR_W  SRAM write address
sram_write_data  output  32  SRAM write data
sram_read_address  output  ADDR_W  SRAM read address
sram_read_data  input  32  SRAM read data, 1-cycle latency
result_valid  output  1  result word available
result_data  output  32  accumulated result from SRAM[N+1]
result_ready  input  1  consumer accepts result
err_overflow  output  1  sticky: job exceeded MAX_N words
err_timeout  output  1  sticky: accumulator handshake timed out

Behaviour:
- Reset: reset_n is synchronous, active-low, clock clk. While reset_n=0: state=LOAD, wptr=1, cnt=0, timer=0. All outputs 0 except sram_grant=1; in_ready=0; result_data=0; err flags=0.
- States: LOAD, WR_CNT, START, WAIT_BUSY, WAIT_DONE, RD_REQ, RD_CAP, PRESENT.
- sram_grant is 0 in START, WAIT_BUSY and WAIT_DONE; 1 in all other states.
- LOAD:
  - in_ready=1.
  - Accept = in_valid & in_ready. If cnt < MAX_N, drive combinationally the same cycle: sram_write_enable=1, write_address=wptr, write_data=in_data. Then wptr++ and cnt++.
  - If cnt == MAX_N, the word is accepted but not written, and err_overflow<=1.
  - The first accepted word of a job clears both error flags.
  - Accept with in_last=1 -> WR_CNT. in_last without in_valid is ignored.
- WR_CNT: one cycle; write_enable=1, address=0, data={zero-extend cnt}; in_ready=0; -> START.
- START:
  - If dut_ready=1: dut_valid=1 for exactly this cycle, timer cleared, -> WAIT_BUSY.
  - Else hold START with dut_valid=0 (no timeout here).
- WAIT_BUSY:
  - dut_ready=0 -> WAIT_DONE with timer cleared.
  - Else timer++; timer reaching TIMEOUT_CYC -> err_timeout<=1, -> LOAD (no result).
- WAIT_DONE:
  - dut_ready=1 -> RD_REQ.
  - Else timer++; same timeout rule as WAIT_BUSY.
- RD_REQ: read_address=cnt+1 (ADDR_W bits); -> RD_CAP.
- RD_CAP: read_address held; result_data<=sram_read_data; -> PRESENT.
- PRESENT:
  - result_valid=1; result_data stable until accepted.
  - result_valid & result_ready -> LOAD, with wptr=1 and cnt=0.
  - result_valid does not depend combinationally on result_ready.
- write_enable is 0 in every state other than LOAD-accept and WR_CNT. read_address is 0 outside RD_REQ/RD_CAP.
- End-to-end latency from last input accept to result_valid: 1 (WR_CNT) + 1 (START, with dut_ready=1) + accumulator busy time + 3 cycles.
- Boundaries:
  - cnt saturates at MAX_N, so the result address never wraps.
  - The error flag of a completed job stays visible until the next job's first accept.
  - Reset mid-job in any state returns to the reset values above; no write or dut_valid is issued in the reset cycle.

Test Plan:
- Job of 3 words 0x3F800000, 0x40000000, 0x40400000 (last on third); model returns 0x40C00000 at SRAM[4] -> writes to addr 1,2,3 then addr0=3; one dut_valid pulse; reads addr 4; result_valid with result_data=0x40C00000.
- Same job with result_ready low for 5 cycles -> result_valid held and result_data stable; next job accepted only after the handshake.
- dut_ready held 0 when START is entered, released after 4 cycles -> dut_valid asserts only in the cycle dut_ready=1, exactly once.
- ADDR_W=4 (MAX_N=14), send 16 words -> 14 written (addr 1..14), addr0=14, err_overflow=1, result read from addr 15.
- dut_ready stuck at 1 after the pulse, TIMEOUT_CYC=8 -> err_timeout=1 after 8 cycles in WAIT_BUSY, return to LOAD, no result_valid; next accepted word clears err_timeout.
- reset_n=0 for 1 cycle during WAIT_DONE -> all outputs at reset values; a new 1-word job then completes normally with the result read from addr 2.

Source files
------------

// File: rtl/accum_job_loader.sv
// Loads a job of FP32 words into SRAM, starts the accumulator with a dut_valid
// pulse, waits for completion and returns the result word from SRAM[N+1].
module accum_job_loader #(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              dut_valid,
  input  logic              dut_ready,
  output logic              sram_grant,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] sram_write_address,
  output logic [31:0]       sram_write_data,
  output logic [ADDR_W-1:0] sram_read_address,
  input  logic [31:0]       sram_read_data,
  output logic              result_valid,
  output logic [31:0]       result_data,
  input  logic              result_ready,
  output logic              err_overflow,
  output logic              err_timeout
);

  localparam logic [ADDR_W-1:0] MAX_N    = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam int                TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_LOAD, S_WR_CNT, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_RD_REQ, S_RD_CAP, S_PRESENT
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wptr_reg, wptr_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [TMR_W-1:0]  timer_reg, timer_next;
  logic [31:0]       result_reg, result_next;
  logic              err_ovf_reg, err_ovf_next;
  logic              err_to_reg, err_to_next;

  logic              in_ready_c, dut_valid_c, grant_c, we_c, rvalid_c;
  logic [ADDR_W-1:0] waddr_c, raddr_c;
  logic [31:0]       wdata_c;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= S_LOAD;
      wptr_reg    <= ONE;
      cnt_reg     <= '0;
      timer_reg   <= '0;
      result_reg  <= '0;
      err_ovf_reg <= 1'b0;
      err_to_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wptr_reg    <= wptr_next;
      cnt_reg     <= cnt_next;
      timer_reg   <= timer_next;
      result_reg  <= result_next;
      err_ovf_reg <= err_ovf_next;
      err_to_reg  <= err_to_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    wptr_next    = wptr_reg;
    cnt_next     = cnt_reg;
    timer_next   = timer_reg;
    result_next  = result_reg;
    err_ovf_next = err_ovf_reg;
    err_to_next  = err_to_reg;
    in_ready_c   = 1'b0;
    dut_valid_c  = 1'b0;
    grant_c      = 1'b1;
    we_c         = 1'b0;
    waddr_c      = '0;
    wdata_c      = '0;
    raddr_c      = '0;
    rvalid_c     = 1'b0;
    case (state_reg)
      S_LOAD: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          // cnt==0 only on the first word of a job, since cnt saturates
          if (cnt_reg == '0) begin
            err_ovf_next = 1'b0;
            err_to_next  = 1'b0;
          end
          if (cnt_reg < MAX_N) begin
            we_c      = 1'b1;
            waddr_c   = wptr_reg;
            wdata_c   = in_data;
            wptr_next = wptr_reg + ONE;
            cnt_next  = cnt_reg + ONE;
          end else begin
            err_ovf_next = 1'b1;
          end
          if (in_last) state_next = S_WR_CNT;
        end
      end
      S_WR_CNT: begin
        we_c       = 1'b1;
        wdata_c    = 32'(cnt_reg);
        state_next = S_START;
      end
      S_START: begin
        grant_c = 1'b0;
        if (dut_ready) begin
          dut_valid_c = 1'b1;
          timer_next  = '0;
          state_next  = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY, S_WAIT_DONE: begin
        grant_c = 1'b0;
        if ((state_reg == S_WAIT_BUSY) && !dut_ready) begin
          timer_next = '0;
          state_next = S_WAIT_DONE;
        end else if ((state_reg == S_WAIT_DONE) && dut_ready) begin
          state_next = S_RD_REQ;
        end else if (timer_reg == TMR_LAST) begin
          err_to_next = 1'b1;
          timer_next  = '0;
          wptr_next   = ONE;
          cnt_next    = '0;
          state_next  = S_LOAD;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      S_RD_REQ: begin
        raddr_c    = cnt_reg + ONE;
        state_next = S_RD_CAP;
      end
      S_RD_CAP: begin
        raddr_c     = cnt_reg + ONE;
        result_next = sram_read_data;
        state_next  = S_PRESENT;
      end
      S_PRESENT: begin
        rvalid_c = 1'b1;
        if (result_ready) begin
          wptr_next  = ONE;
          cnt_next   = '0;
          state_next = S_LOAD;
        end
      end
      default: state_next = S_LOAD;
    endcase
  end

  // Outputs are forced to their idle values for the whole reset cycle
  assign in_ready           = in_ready_c & reset_n;
  assign dut_valid          = dut_valid_c & reset_n;
  assign sram_grant         = grant_c | ~reset_n;
  assign sram_write_enable  = we_c & reset_n;
  assign sram_write_address = reset_n ? waddr_c : '0;
  assign sram_write_data    = reset_n ? wdata_c : '0;
  assign sram_read_address  = reset_n ? raddr_c : '0;
  assign result_valid       = rvalid_c & reset_n;
  assign result_data        = reset_n ? result_reg : '0;
  assign err_overflow       = err_ovf_reg & reset_n;
  assign err_timeout        = err_to_reg & reset_n;

endmodule

// File: tb/tb_accum_job_loader.sv
// Randomized scoreboard bench for accum_job_loader with SRAM and accumulator models.
module tb_accum_job_loader;
  localparam int ADDR_W = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam int MAX_N = 14;

  logic clk = 1'b0;
  logic reset_n;
  logic in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic dut_valid, dut_ready, sram_grant, sram_write_enable;
  logic [ADDR_W-1:0] sram_write_address, sram_read_address;
  logic [31:0] sram_write_data, sram_read_data;
  logic result_valid, result_ready, err_overflow, err_timeout;
  logic [31:0] result_data;

  always #5 clk = ~clk;

  accum_job_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .dut_valid(dut_valid), .dut_ready(dut_ready), .sram_grant(sram_grant),
    .sram_write_enable(sram_write_enable), .sram_write_address(sram_write_address),
    .sram_write_data(sram_write_data), .sram_read_address(sram_read_address),
    .sram_read_data(sram_read_data), .result_valid(result_valid), .result_data(result_data),
    .result_ready(result_ready), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  typedef struct { logic [31:0] data; logic ovf; } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int results_seen = 0;
  int job_p0 = 0;
  bit stuck = 0, hold_low = 0, rr_hold = 0;
  logic acc_ready = 1'b1;
  logic [31:0] mem [0:15];

  assign dut_ready = acc_ready & ~hold_low;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] real_to_f32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real f32_to_real(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  // SRAM: loader port only when granted, 1-cycle read latency
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
  end
  always @(posedge clk) begin
    sram_read_data <= mem[sram_read_address];
    if (sram_grant && sram_write_enable) mem[sram_write_address] = sram_write_data;
  end

  always @(negedge clk) begin
    check("write_without_grant", 32'(sram_write_enable & ~sram_grant), 32'd0);
    check("dut_valid_while_busy", 32'(dut_valid & ~dut_ready), 32'd0);
  end

  // Accumulator model: sums SRAM[1..N] as floats, writes SRAM[N+1]
  initial begin
    int n;
    real s;
    forever begin
      @(negedge clk); #1;
      while (dut_valid) begin
        pulses++;
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (!stuck) begin
          acc_ready = 1'b0;
          n = int'(mem[0]);
          s = 0.0;
          for (int i = 1; i <= n && i < 16; i++) s += f32_to_real(mem[i]);
          repeat ($urandom_range(1, 5)) @(negedge clk);
          if (n < 15) mem[n+1] = real_to_f32(s);
          acc_ready = 1'b1;
        end
        #1;
      end
    end
  end

  // Monitor: drives result_ready, pops scoreboard on each handshake
  initial begin
    logic pv;
    logic [31:0] pd;
    exp_t e;
    pv = 1'b0;
    pd = 32'd0;
    forever begin
      @(negedge clk);
      if (pv) begin
        check("result_held", 32'(result_valid), 32'd1);
        check("result_stable", result_data, pd);
      end
      result_ready = rr_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (result_valid && result_ready) begin
        results_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_result: got %h, expected no result", result_data);
        end else begin
          e = exp_q.pop_front();
          check("result_data", result_data, e.data);
          check("result_err_overflow", 32'(err_overflow), 32'(e.ovf));
          $display("result %h expected %h ovf=%0d", result_data, e.data, err_overflow);
        end
        pv = 1'b0;
      end else begin
        pv = result_valid;
        pd = result_data;
      end
    end
  end

  task automatic wait_in_ready(input string tag);
    int b = 0;
    while (!in_ready && b < 300) begin
      @(negedge clk);
      b++;
    end
    check(tag, 32'(in_ready), 32'd1);
  endtask

  task automatic send_job(input int n, input bit directed, input bit push_exp);
    logic [31:0] w;
    real s;
    exp_t e;
    s = 0.0;
    wait_in_ready("idle_before_job");
    job_p0 = pulses;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_last = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      w = directed ? real_to_f32(real'(i + 1)) : real_to_f32(real'($urandom_range(1, 1000)));
      if (i < MAX_N) s += f32_to_real(w);
      in_valid = 1'b1;
      in_data = w;
      in_last = (i == n - 1);
      check("in_ready_during_job", 32'(in_ready), 32'd1);
      @(negedge clk);
      if (i == 0) begin
        check("err_timeout_cleared", 32'(err_timeout), 32'd0);
        check("err_overflow_cleared", 32'(err_overflow), 32'd0);
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (push_exp) begin
      e.data = (directed && n == 3) ? 32'h40C00000 : real_to_f32(s);
      e.ovf = (n > MAX_N);
      exp_q.push_back(e);
    end
    $display("job sent: %0d words, expect_result=%0d", n, push_exp);
  endtask

  task automatic end_job();
    wait_in_ready("job_complete");
    check("dut_valid_pulses", 32'(pulses - job_p0), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sram_grant", 32'(sram_grant), 32'd1);
    check("rst_write_enable", 32'(sram_write_enable), 32'd0);
    check("rst_dut_valid", 32'(dut_valid), 32'd0);
    check("rst_read_address", 32'(sram_read_address), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_result_data", result_data, 32'd0);
    check("rst_errs", {30'd0, err_overflow, err_timeout}, 32'd0);
  endtask

  initial begin
    int b;
    int rs;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 32'd0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset_n = 1'b1;
    @(negedge clk);

    // Basic 3-word job: 1.0 + 2.0 + 3.0
    send_job(3, 1'b1, 1'b1);
    end_job();
    check("job_count_addr0", mem[0], 32'd3);

    // Result held while consumer stalls
    rr_hold = 1;
    send_job(3, 1'b1, 1'b1);
    b = 0;
    while (!result_valid && b < 100) begin @(negedge clk); b++; end
    check("result_valid_seen", 32'(result_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("no_accept_before_handshake", 32'(in_ready), 32'd0);
    end
    rr_hold = 0;
    end_job();

    // Accumulator not ready when START is entered
    hold_low = 1;
    send_job(2, 1'b0, 1'b1);
    b = 0;
    while (sram_grant && b < 50) begin @(negedge clk); b++; end
    check("reached_start", 32'(sram_grant), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("no_pulse_while_not_ready", 32'(pulses - job_p0), 32'd0);
    end
    hold_low = 0;
    end_job();

    // Overflow: 16 words, 14 stored
    send_job(16, 1'b0, 1'b1);
    end_job();
    check("ovf_count_addr0", mem[0], 32'd14);
    check("ovf_flag_sticky", 32'(err_overflow), 32'd1);

    // Accumulator never goes busy -> timeout, no result
    stuck = 1;
    rs = results_seen;
    send_job(2, 1'b0, 1'b0);
    end_job();
    stuck = 0;
    check("timeout_flag", 32'(err_timeout), 32'd1);
    check("timeout_no_result", 32'(results_seen - rs), 32'd0);

    for (int j = 0; j < 8; j++) begin
      send_job($urandom_range(1, 6), 1'b0, 1'b1);
      end_job();
    end

    // Reset while the accumulator is busy
    send_job(4, 1'b0, 1'b0);
    b = 0;
    while (!(acc_ready == 1'b0 && !sram_grant) && b < 100) begin @(negedge clk); b++; end
    check("reached_wait_done", 32'(sram_grant), 32'd0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    send_job(1, 1'b0, 1'b1);
    end_job();
    check("one_word_count_addr0", mem[0], 32'd1);

    b = 0;
    while (exp_q.size() != 0 && b < 200) begin @(negedge clk); b++; end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end
endmodule
